vga_vtiming_param: RTL and testbench
====================================

# vga_vtiming_param

Parametrised vertical timing generator for the VGA driver: counts horizontal lines, not raw clock cycles, and sequences active video, front porch, sync pulse and back porch. The horizontal timing block provides a one-cycle `line_tick` at the end of every scan line. Porch and sync lengths, sync polarity and the row-replication factor used to scale the BRAM image are parameters. Outputs drive VSYNC at the connector, the BRAM row address (VPIXEL), and blanking and frame-start qualifiers for the pixel pipeline.

## Interface
- `V_ACTIVE`, 480, active lines per frame; must be a multiple of `ROW_SCALE`.
- `V_FP`, 10, front-porch lines; ≥1.
- `V_SYNC`, 2, sync-pulse lines; ≥1.
- `V_BP`, 33, back-porch lines; ≥1.
- `ROW_SCALE`, 5, screen lines per BRAM row; ≥1.
- `ROW_W`, 7, VPIXEL width; must hold `V_ACTIVE/ROW_SCALE-1`.
- `SYNC_POL`, 0, asserted level of VSYNC (0 = active-low).
- `FRAME_W`, 8, frame counter width.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `en`  in  1  when low, `line_tick` is ignored and all state holds.
- `line_tick`  in  1  one-cycle pulse per completed horizontal line.
- `VSYNC`  out  1  vertical sync, polarity per `SYNC_POL`.
- `VPIXEL`  out  ROW_W  BRAM row index during active video; 0 outside it.
- `vactive`  out  1  high while in ACTIVE.
- `frame_start`  out  1  one-cycle pulse on entry to ACTIVE from BACK.
- `line_num`  out  12  absolute line in frame, 0..V_TOTAL-1 (V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP).
- `frame_cnt`  out  FRAME_W  completed-frame count, wraps modulo 2^FRAME_W.

## Operation
- States: ACTIVE, FRONT, SYNC, BACK. The current state has a per-state line counter `seg_cnt` (12 bit).
- All state advances only on a clock edge where `en=1` and `line_tick=1` (an "advancing edge"). Other edges hold everything.
- On an advancing edge in a state of length L:
  - if `seg_cnt == L-1`, move to the next state (ACTIVE→FRONT→SYNC→BACK→ACTIVE) and clear `seg_cnt`;
  - otherwise increment `seg_cnt`.
- Row replication in ACTIVE: `rep_cnt` counts 0..ROW_SCALE-1 per advancing edge.
  - When it wraps, VPIXEL increments.
  - The final wrap, on leaving ACTIVE, sets VPIXEL to 0 instead of `V_ACTIVE/ROW_SCALE`.
  - `rep_cnt` and VPIXEL are cleared on leaving ACTIVE and hold 0 through FRONT/SYNC/BACK.
- `line_num`: increments on every advancing edge and wraps from V_TOTAL-1 to 0 on the BACK→ACTIVE transition.
- `frame_cnt`: increments on the BACK→ACTIVE transition.
- VSYNC equals `SYNC_POL` in SYNC and `~SYNC_POL` elsewhere.
- `vactive` is high in ACTIVE only.
- `frame_start` is high for exactly the one cycle following the BACK→ACTIVE edge.
- Illegal parameters (zero porch or sync, non-divisible `V_ACTIVE`) must fail elaboration via a generate-time check.

## Timing
- Reset values: state ACTIVE, `seg_cnt`=0, `rep_cnt`=0, VPIXEL=0, `vactive`=1, VSYNC=`~SYNC_POL`, `frame_start`=0, `line_num`=0, `frame_cnt`=0.
- All outputs are registered. They reflect the new state in the cycle immediately after the advancing edge, i.e. one-clock latency from `line_tick`. There are no combinational paths from inputs to outputs.
- Back-to-back `line_tick` on consecutive cycles is legal. Each pulse advances exactly one line.
- `line_tick` with `en=0` is dropped, not deferred.
- `reset` asserted at any time, including mid-SYNC, immediately forces reset values. The first advancing edge after release counts as active line 0 → 1.
- Frame period is exactly V_TOTAL advancing edges.
- VSYNC is asserted for exactly `V_SYNC` lines.
- Each VPIXEL value is held for exactly `ROW_SCALE` lines.

## Test plan
- Small config (V_ACTIVE=6, V_FP=2, V_SYNC=1, V_BP=3, ROW_SCALE=3, SYNC_POL=0), ticks every 4 cycles → VPIXEL sequence 0,0,0,1,1,1 then 0 for 6 lines; VSYNC low only on `line_num` 8; `frame_start` pulses once per 12 ticks; `frame_cnt` reaches 2 after 24 ticks.
- Same config, `line_tick` on consecutive cycles → identical sequence compressed in time; no tick is lost; `line_num` wraps 11→0.
- SYNC_POL=1, defaults (480/10/2/33, scale 5) → VSYNC high exactly on `line_num` 490–491; VPIXEL max 95; V_TOTAL 525.
- `en=0` for 10 ticks mid-ACTIVE → all outputs frozen; counting resumes from the same line when `en` returns high.
- Assert `reset` during SYNC → next cycle VSYNC=1, `vactive`=1, VPIXEL=0, `line_num`=0, `frame_cnt`=0.
- FRAME_W=2, run 5 frames → `frame_cnt` sequence 1,2,3,0,1.

Source files
------------

// File: rtl/vga_vtiming_param_if.sv
// rtl/vga_vtiming_param_if.sv - line-tick inputs and vertical timing outputs of the VGA vertical timer
interface vga_vtiming_param_if #(
    parameter int ROW_W   = 7,
    parameter int FRAME_W = 8
) ();
    logic               en;
    logic               line_tick;
    logic               VSYNC;
    logic [ROW_W-1:0]   VPIXEL;
    logic               vactive;
    logic               frame_start;
    logic [11:0]        line_num;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (
        output en, line_tick,
        input  VSYNC, VPIXEL, vactive, frame_start, line_num, frame_cnt
    );

    modport slave (
        input  en, line_tick,
        output VSYNC, VPIXEL, vactive, frame_start, line_num, frame_cnt
    );
endinterface

// File: rtl/vga_vtiming_param.sv
// rtl/vga_vtiming_param.sv - line-counting vertical timing generator with BRAM row replication
module vga_vtiming_param #(
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int ROW_SCALE = 5,
    parameter int ROW_W     = 7,
    parameter bit SYNC_POL  = 1'b0,
    parameter int FRAME_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    vga_vtiming_param_if.slave vt
);
    localparam int RS_SAFE = (ROW_SCALE < 1) ? 1 : ROW_SCALE;

    generate
        if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || ROW_SCALE < 1) begin : g_bad_len
            $error("vga_vtiming_param: V_ACTIVE, V_FP, V_SYNC, V_BP and ROW_SCALE must all be >= 1");
        end
        if ((V_ACTIVE % RS_SAFE) != 0) begin : g_bad_scale
            $error("vga_vtiming_param: V_ACTIVE must be a multiple of ROW_SCALE");
        end
        if ((V_ACTIVE / RS_SAFE - 1) >= (1 << ROW_W)) begin : g_bad_row_w
            $error("vga_vtiming_param: ROW_W too narrow for V_ACTIVE/ROW_SCALE-1");
        end
    endgenerate

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_FRONT  = 2'd1;
    localparam logic [1:0] ST_SYNC   = 2'd2;
    localparam logic [1:0] ST_BACK   = 2'd3;

    localparam logic [11:0] ACT_LAST   = 12'(V_ACTIVE - 1);
    localparam logic [11:0] FP_LAST    = 12'(V_FP - 1);
    localparam logic [11:0] SYNC_LAST  = 12'(V_SYNC - 1);
    localparam logic [11:0] BP_LAST    = 12'(V_BP - 1);
    localparam logic [11:0] REP_LAST   = 12'(RS_SAFE - 1);

    logic [1:0]         state_q, state_d;
    logic [11:0]        seg_cnt_q, seg_cnt_d;
    logic [11:0]        rep_cnt_q, rep_cnt_d;
    logic [ROW_W-1:0]   vpixel_q, vpixel_d;
    logic [11:0]        line_num_q, line_num_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               frame_start_q, frame_start_d;
    logic               vsync_q, vsync_d;
    logic               vactive_q, vactive_d;
    logic [11:0]        seg_last;
    logic               adv;
    logic               seg_done;

    assign adv = vt.en & vt.line_tick;

    always_comb begin
        seg_last = ACT_LAST;
        case (state_q)
            ST_ACTIVE: seg_last = ACT_LAST;
            ST_FRONT:  seg_last = FP_LAST;
            ST_SYNC:   seg_last = SYNC_LAST;
            default:   seg_last = BP_LAST;
        endcase
    end

    assign seg_done = (seg_cnt_q == seg_last);

    always_comb begin
        state_d       = state_q;
        seg_cnt_d     = seg_cnt_q;
        rep_cnt_d     = rep_cnt_q;
        vpixel_d      = vpixel_q;
        line_num_d    = line_num_q;
        frame_cnt_d   = frame_cnt_q;
        frame_start_d = 1'b0;
        if (adv) begin
            line_num_d = line_num_q + 12'd1;
            if (seg_done) begin
                seg_cnt_d = 12'd0;
                case (state_q)
                    ST_ACTIVE: state_d = ST_FRONT;
                    ST_FRONT:  state_d = ST_SYNC;
                    ST_SYNC:   state_d = ST_BACK;
                    default:   state_d = ST_ACTIVE;
                endcase
            end else begin
                seg_cnt_d = seg_cnt_q + 12'd1;
            end
            // V_ACTIVE is a multiple of ROW_SCALE, so the last active line always lands on a row wrap.
            if (state_q == ST_ACTIVE) begin
                if (rep_cnt_q == REP_LAST) begin
                    rep_cnt_d = 12'd0;
                    vpixel_d  = seg_done ? '0 : vpixel_q + ROW_W'(1);
                end else begin
                    rep_cnt_d = rep_cnt_q + 12'd1;
                end
            end else begin
                rep_cnt_d = 12'd0;
                vpixel_d  = '0;
            end
            if (state_q == ST_BACK && seg_done) begin
                line_num_d    = 12'd0;
                frame_cnt_d   = frame_cnt_q + FRAME_W'(1);
                frame_start_d = 1'b1;
            end
        end
    end

    assign vsync_d   = (state_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    assign vactive_d = (state_d == ST_ACTIVE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_ACTIVE;
            seg_cnt_q     <= 12'd0;
            rep_cnt_q     <= 12'd0;
            vpixel_q      <= '0;
            line_num_q    <= 12'd0;
            frame_cnt_q   <= '0;
            frame_start_q <= 1'b0;
            vsync_q       <= ~SYNC_POL;
            vactive_q     <= 1'b1;
        end else begin
            state_q       <= state_d;
            seg_cnt_q     <= seg_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            vpixel_q      <= vpixel_d;
            line_num_q    <= line_num_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_start_q <= frame_start_d;
            vsync_q       <= vsync_d;
            vactive_q     <= vactive_d;
        end
    end

    assign vt.VSYNC       = vsync_q;
    assign vt.VPIXEL      = vpixel_q;
    assign vt.vactive     = vactive_q;
    assign vt.frame_start = frame_start_q;
    assign vt.line_num    = line_num_q;
    assign vt.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_vga_vtiming_param.sv
// tb/tb_vga_vtiming_param.sv - directed bench for vga_vtiming_param (small, default and narrow-frame configs)
module tb_vga_vtiming_param;
    logic clk = 1'b0;
    logic reset;
    int   n_err = 0;
    int   n_chk = 0;

    always #5 clk = ~clk;

    vga_vtiming_param_if #(.ROW_W(2), .FRAME_W(8)) s_if ();
    vga_vtiming_param_if #(.ROW_W(7), .FRAME_W(8)) b_if ();
    vga_vtiming_param_if #(.ROW_W(2), .FRAME_W(2)) f_if ();

    vga_vtiming_param #(
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(1), .V_BP(3), .ROW_SCALE(3),
        .ROW_W(2), .SYNC_POL(1'b0), .FRAME_W(8)
    ) u_small (.clk(clk), .reset(reset), .vt(s_if));

    vga_vtiming_param #(
        .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33), .ROW_SCALE(5),
        .ROW_W(7), .SYNC_POL(1'b1), .FRAME_W(8)
    ) u_big (.clk(clk), .reset(reset), .vt(b_if));

    vga_vtiming_param #(
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(1), .V_BP(3), .ROW_SCALE(3),
        .ROW_W(2), .SYNC_POL(1'b0), .FRAME_W(2)
    ) u_fw (.clk(clk), .reset(reset), .vt(f_if));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected small-config outputs after t advancing edges since reset (12-line frame).
    task automatic chk_small(input int t, input string tag);
        int ln;
        ln = t % 12;
        chk({tag, ".line_num"},  32'(s_if.line_num),  32'(ln));
        chk({tag, ".vactive"},   32'(s_if.vactive),   32'(ln < 6));
        chk({tag, ".VPIXEL"},    32'(s_if.VPIXEL),    32'((ln < 6) ? ln / 3 : 0));
        chk({tag, ".VSYNC"},     32'(s_if.VSYNC),     32'((ln == 8) ? 0 : 1));
        chk({tag, ".frame_cnt"}, 32'(s_if.frame_cnt), 32'((t / 12) % 256));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic tick_s();
        s_if.line_tick = 1'b1;
        @(negedge clk);
        s_if.line_tick = 1'b0;
    endtask

    initial begin
        int fs_seen;
        int max_pix;
        int sync_lines;
        int ln;
        int fexp [5];
        fexp = '{1, 2, 3, 0, 1};

        reset = 1'b1;
        s_if.en = 1'b1; s_if.line_tick = 1'b0;
        b_if.en = 1'b1; b_if.line_tick = 1'b0;
        f_if.en = 1'b1; f_if.line_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        chk_small(0, "rst");
        chk("rst.frame_start", 32'(s_if.frame_start), 32'd0);
        chk("rst.big_VSYNC",   32'(b_if.VSYNC),       32'd0);

        // Ticks spaced four cycles apart.
        fs_seen = 0;
        for (int t = 1; t <= 24; t++) begin
            tick_s();
            chk_small(t, "spaced");
            chk("spaced.frame_start", 32'(s_if.frame_start), 32'(t % 12 == 0));
            fs_seen += int'(s_if.frame_start);
            @(negedge clk);
            chk("spaced.fs_drop", 32'(s_if.frame_start), 32'd0);
            repeat (2) @(negedge clk);
        end
        chk("spaced.fs_count", 32'(fs_seen), 32'd2);

        // Back-to-back ticks.
        do_reset();
        s_if.line_tick = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            @(negedge clk);
            chk_small(t, "b2b");
            chk("b2b.frame_start", 32'(s_if.frame_start), 32'(t % 12 == 0));
        end
        s_if.line_tick = 1'b0;

        // en low drops ticks mid-ACTIVE.
        do_reset();
        tick_s();
        tick_s();
        chk_small(2, "pre_en");
        s_if.en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick_s();
            chk_small(2, "en_low");
        end
        s_if.en = 1'b1;
        tick_s();
        chk_small(3, "en_back");

        // Asynchronous reset while in SYNC of the second frame.
        do_reset();
        for (int i = 0; i < 20; i++) tick_s();
        chk_small(20, "in_sync");
        reset = 1'b1;
        #1;
        chk("rst_sync.VSYNC",     32'(s_if.VSYNC),     32'd1);
        chk("rst_sync.vactive",   32'(s_if.vactive),   32'd1);
        chk("rst_sync.VPIXEL",    32'(s_if.VPIXEL),    32'd0);
        chk("rst_sync.line_num",  32'(s_if.line_num),  32'd0);
        chk("rst_sync.frame_cnt", 32'(s_if.frame_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick_s();
        chk_small(1, "post_rst");

        // Default geometry, active-high sync, two full frames.
        do_reset();
        max_pix = 0;
        sync_lines = 0;
        b_if.line_tick = 1'b1;
        for (int t = 1; t <= 1050; t++) begin
            @(negedge clk);
            ln = t % 525;
            chk("big.line_num", 32'(b_if.line_num), 32'(ln));
            chk("big.VSYNC",    32'(b_if.VSYNC),    32'(ln >= 490 && ln <= 491));
            chk("big.vactive",  32'(b_if.vactive),  32'(ln < 480));
            chk("big.VPIXEL",   32'(b_if.VPIXEL),   32'((ln < 480) ? ln / 5 : 0));
            if (int'(b_if.VPIXEL) > max_pix) max_pix = int'(b_if.VPIXEL);
            sync_lines += int'(b_if.VSYNC);
        end
        b_if.line_tick = 1'b0;
        chk("big.max_vpixel", 32'(max_pix),         32'd95);
        chk("big.sync_lines", 32'(sync_lines),      32'd4);
        chk("big.frame_cnt",  32'(b_if.frame_cnt),  32'd2);

        // Two-bit frame counter over five frames.
        do_reset();
        f_if.line_tick = 1'b1;
        for (int t = 1; t <= 60; t++) begin
            @(negedge clk);
            if (t % 12 == 0)
                chk("fw.frame_cnt", 32'(f_if.frame_cnt), 32'(fexp[t / 12 - 1]));
        end
        f_if.line_tick = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
